div_unit: RTL and testbench

Iterative 32-bit signed integer divider serving as the multicycle responder to the ALU's divide request. The ALU pulses `ctrl_DIV` with operands; the block runs one restoring-division step per clock and returns quotient, exception flag and a one-cycle ready pulse. It sits beside the single-cycle bitwise/arithmetic ALU datapath and stalls the pipeline until `data_resultRDY`.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_if.sv | 23 ++
 rtl/div_step.sv | 19 +
 rtl/div_unit.sv | 98 +++++++++
 tb/tb_div_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types, constants and the two's-complement helper for the iterative
// signed divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_STEPS = 32;
    localparam int CNT_W     = 6;

    localparam logic [DIV_WIDTH-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_e;

    function automatic logic [DIV_WIDTH-1:0] twos_neg(input logic [DIV_WIDTH-1:0] value);
        return ~value + DIV_WIDTH'(1);
    endfunction

endpackage

// File: rtl/div_if.sv
// Request/response bundle between the ALU (master) and the divider (slave).
interface div_if import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
);

    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY
    );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module div_step import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             quot_bit
);

    // One extra bit keeps the shifted remainder exact before the compare.
    logic [WIDTH:0] shifted;

    assign shifted  = {rem_in, dividend_bit};
    assign quot_bit = (shifted >= {1'b0, divisor});
    assign rem_out  = WIDTH'(quot_bit ? shifted - {1'b0, divisor} : shifted);

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit signed divider: magnitude restoring division, one step per
// clock, sign applied when the result is registered.
module div_unit import div_pkg::*; (
    input logic  clock,
    input logic  reset,
    div_if.slave bus
);

    localparam int               MSB      = DIV_WIDTH - 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_STEPS);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [MSB:0]     dividend_q, divisor_q, rem_q, quot_q, result_q;
    logic             sign_q, ovf_q, zero_q, exc_q;

    logic [MSB:0] abs_a, abs_b, rem_next;
    logic         quot_bit, start, steps_done, div_zero;

    assign start      = bus.ctrl_DIV;
    assign steps_done = (cnt_q == LAST_CNT);
    assign div_zero   = (bus.data_operandB == '0);
    assign abs_a      = bus.data_operandA[MSB] ? twos_neg(bus.data_operandA) : bus.data_operandA;
    assign abs_b      = bus.data_operandB[MSB] ? twos_neg(bus.data_operandB) : bus.data_operandB;

    div_step #(.WIDTH(DIV_WIDTH)) u_step (
        .rem_in       (rem_q),
        .dividend_bit (dividend_q[MSB]),
        .divisor      (divisor_q),
        .rem_out      (rem_next),
        .quot_bit     (quot_bit)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RUN;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                RUN:     if (steps_done) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.data_resultRDY = (state_q == DONE);
        bus.data_result    = result_q;
        bus.data_exception = exc_q;
    end

    // A zero divisor preloads the counter as exhausted, so the next edge
    // lands in DONE with the exception result and no steps are run.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            sign_q     <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
            result_q   <= '0;
            exc_q      <= 1'b0;
        end else if (start) begin
            cnt_q      <= div_zero ? LAST_CNT : '0;
            dividend_q <= abs_a;
            divisor_q  <= abs_b;
            rem_q      <= '0;
            quot_q     <= '0;
            sign_q     <= bus.data_operandA[MSB] ^ bus.data_operandB[MSB];
            ovf_q      <= (bus.data_operandA == INT_MIN) && (bus.data_operandB == '1);
            zero_q     <= div_zero;
        end else if (state_q == RUN) begin
            if (steps_done) begin
                result_q <= zero_q ? '0 : (sign_q ? twos_neg(quot_q) : quot_q);
                exc_q    <= ovf_q | zero_q;
            end else begin
                cnt_q      <= cnt_q + CNT_W'(1);
                rem_q      <= rem_next;
                dividend_q <= {dividend_q[MSB-1:0], 1'b0};
                quot_q     <= {quot_q[MSB-1:0], quot_bit};
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: a reference model fills a scoreboard at
// each start; entries are popped and compared on each ready pulse.
module tb_div_unit;

    typedef struct packed {
        logic [31:0] result;
        logic        exc;
    } exp_t;

    logic clock;
    logic reset;
    int   pass_cnt;
    int   total_cnt;
    exp_t exp_q[$];

    div_if #(.WIDTH(32)) bus ();

    div_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (b == 32'd0) begin
            e.result = 32'd0;
            e.exc    = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.result = 32'h8000_0000;
            e.exc    = 1'b1;
        end else begin
            e.result = 32'($signed(a) / $signed(b));
            e.exc    = 1'b0;
        end
        return e;
    endfunction

    // Caller positions time away from the rising edge before calling.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit push);
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        if (push) exp_q.push_back(model(a, b));
        @(posedge clock);
        #1;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    task automatic wait_result(input string name, input int exp_lat, input bit check_width);
        int   n;
        bit   seen;
        exp_t e;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (bus.data_resultRDY) seen = 1'b1;
        end
        total_cnt++;
        if (!seen || exp_q.size() == 0) begin
            $display("FAIL %s_ready: no ready pulse within 40 cycles or empty scoreboard (seen=%0b queued=%0d)",
                     name, seen, exp_q.size());
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        pass_cnt++;
        e = exp_q.pop_front();
        total_cnt++;
        if (n !== exp_lat) $display("FAIL %s_latency: got %0d expected %0d", name, n, exp_lat);
        else pass_cnt++;
        total_cnt++;
        if (bus.data_result !== e.result)
            $display("FAIL %s_result: got %h expected %h", name, bus.data_result, e.result);
        else pass_cnt++;
        total_cnt++;
        if (bus.data_exception !== e.exc)
            $display("FAIL %s_exception: got %b expected %b", name, bus.data_exception, e.exc);
        else pass_cnt++;
        if (check_width) begin
            @(negedge clock);
            total_cnt++;
            if (bus.data_resultRDY !== 1'b0)
                $display("FAIL %s_pulse_width: ready got %b expected 0 one cycle later", name, bus.data_resultRDY);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        total_cnt++;
        if (bus.data_result !== 32'd0) $display("FAIL reset_result: got %h expected 0", bus.data_result);
        else pass_cnt++;
        total_cnt++;
        if (bus.data_exception !== 1'b0) $display("FAIL reset_exception: got %b expected 0", bus.data_exception);
        else pass_cnt++;
        total_cnt++;
        if (bus.data_resultRDY !== 1'b0) $display("FAIL reset_ready: got %b expected 0", bus.data_resultRDY);
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_signs();
        logic [31:0] a_tab [4] = '{32'd100, -32'sd100, 32'd100, -32'sd100};
        logic [31:0] b_tab [4] = '{32'd7, 32'd7, -32'sd7, -32'sd7};
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            start_op(a_tab[i], b_tab[i], 1'b1);
            wait_result($sformatf("signs%0d", i), 33, 1'b1);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = (i % 2 == 0) ? $urandom : $urandom_range(1, 1000);
            if (b == 32'd0) b = 32'd3;
            if (i == 3) b = -b;
            @(negedge clock);
            start_op(a, b, 1'b1);
            wait_result($sformatf("random%0d", i), 33, 1'b1);
        end
    endtask

    task automatic test_div_zero();
        @(negedge clock);
        start_op(32'd5, 32'd0, 1'b1);
        wait_result("div_zero", 1, 1'b1);
    endtask

    task automatic test_overflow();
        @(negedge clock);
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_result("overflow", 33, 1'b1);
        @(negedge clock);
        start_op(32'h8000_0000, 32'd1, 1'b1);
        wait_result("int_min_by_one", 33, 1'b1);
    endtask

    task automatic test_abort();
        int rdy_seen;
        rdy_seen = 0;
        @(negedge clock);
        start_op(32'd1000, 32'd10, 1'b0);
        // Ten falling edges put the restart on the tenth rising edge after start.
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (bus.data_resultRDY) rdy_seen++;
        end
        total_cnt++;
        if (rdy_seen !== 0) $display("FAIL abort_no_early_ready: got %0d pulses expected 0", rdy_seen);
        else pass_cnt++;
        start_op(32'd81, 32'd9, 1'b1);
        wait_result("abort_restart", 33, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        int rdy_seen;
        rdy_seen = 0;
        total_cnt++;
        if (bus.data_result !== 32'd9) $display("FAIL hold_before_reset: got %h expected 00000009", bus.data_result);
        else pass_cnt++;
        @(negedge clock);
        start_op(32'd50, 32'd5, 1'b0);
        repeat (19) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (bus.data_result !== 32'd0 || bus.data_exception !== 1'b0 || bus.data_resultRDY !== 1'b0)
            $display("FAIL async_reset_outputs: got result=%h exc=%b rdy=%b expected all 0",
                     bus.data_result, bus.data_exception, bus.data_resultRDY);
        else pass_cnt++;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.data_resultRDY) rdy_seen++;
        end
        total_cnt++;
        if (rdy_seen !== 0) $display("FAIL reset_discards_op: got %0d pulses expected 0", rdy_seen);
        else pass_cnt++;
        @(negedge clock);
        start_op(32'd50, 32'd5, 1'b1);
        wait_result("after_reset", 33, 1'b1);
    endtask

    task automatic test_back_to_back();
        exp_t first;
        @(negedge clock);
        start_op(32'd1000, -32'sd3, 1'b1);
        first = model(32'd1000, -32'sd3);
        wait_result("b2b_first", 33, 1'b0);
        // Still inside the DONE cycle: the new start shares that edge.
        start_op(32'd12345, 32'd11, 1'b1);
        repeat (4) @(posedge clock);
        @(negedge clock);
        total_cnt++;
        if (bus.data_result !== first.result || bus.data_resultRDY !== 1'b0)
            $display("FAIL b2b_hold: got result=%h rdy=%b expected result=%h rdy=0",
                     bus.data_result, bus.data_resultRDY, first.result);
        else pass_cnt++;
        wait_result("b2b_second", 29, 1'b1);
    endtask

    initial begin
        pass_cnt          = 0;
        total_cnt         = 0;
        reset             = 1'b1;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;

        test_reset();
        test_signs();
        test_div_zero();
        test_overflow();
        test_random();
        test_abort();
        test_reset_mid_run();
        test_back_to_back();

        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drained: got %0d entries expected 0", exp_q.size());
        else pass_cnt++;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
